// File: rtl/alu_taylor_arg_prep_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the Taylor cosine argument feeder.
package alu_taylor_arg_prep_pkg;

  localparam logic [2:0]         TAYLOR_FUNC_COS = 3'h0;
  localparam logic [17:0]        PI_2_Q16        = 18'h19220;
  localparam logic signed [17:0] Q16_ONE         = 18'sh10000;

  typedef enum logic [1:0] {
    StIdle,
    StScale,
    StIssue,
    StWait
  } state_t;

  // Quarter-turn fraction to radians: (frac * pi/2) >> 16, always below pi/2.
  function automatic logic [17:0] quarter_angle(logic [15:0] frac);
    logic [32:0] prod;
    prod = {17'd0, frac} * {16'd0, PI_2_Q16[16:0]};
    return {1'b0, prod[32:16]};
  endfunction

  // The clamp keeps the magnitude at or below 1.0, so the negation cannot overflow.
  function automatic logic signed [17:0] fix_result(logic signed [17:0] res, logic neg);
    logic signed [17:0] clamped;
    if (res > Q16_ONE) begin
      clamped = Q16_ONE;
    end else if (res < -Q16_ONE) begin
      clamped = -Q16_ONE;
    end else begin
      clamped = res;
    end
    return neg ? -clamped : clamped;
  endfunction

endpackage

// File: rtl/alu_quadrant_fold.sv
// Folds a quadrant and registered angle into the [0, pi/2] Taylor argument plus the result sign.
module alu_quadrant_fold
  import alu_taylor_arg_prep_pkg::*;
(
  input  logic [1:0]         quadrant,
  input  logic [17:0]        theta,
  output logic signed [17:0] x,
  output logic               sign
);

  // Odd quadrants run the angle backwards from pi/2 (cos symmetry).
  assign x    = quadrant[0] ? signed'(PI_2_Q16 - theta) : signed'(theta);
  assign sign = quadrant[0] ^ quadrant[1];

endmodule

// File: rtl/alu_taylor_arg_prep.sv
// Stereo phase-to-cosine request sequencer: folds phases, drives the Taylor ALU, fixes up results.
module alu_taylor_arg_prep
  import alu_taylor_arg_prep_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               phase_valid,
  input  logic [17:0]        phase_l,
  input  logic [17:0]        phase_r,
  output logic               busy,
  output logic               calc_start,
  output logic [2:0]         calc_func_sel,
  output logic signed [17:0] calc_xl,
  output logic signed [17:0] calc_xr,
  input  logic               calc_done,
  input  logic signed [17:0] calc_resl,
  input  logic signed [17:0] calc_resr,
  output logic               sample_valid,
  output logic signed [17:0] sample_l,
  output logic signed [17:0] sample_r,
  output logic               timeout,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic [17:0] phase_l_q, phase_l_d, phase_r_q, phase_r_d;
  logic [17:0] theta_l_q, theta_l_d, theta_r_q, theta_r_d;
  logic sign_l_q, sign_l_d, sign_r_q, sign_r_d;
  logic calc_start_q, calc_start_d;
  logic signed [17:0] calc_xl_q, calc_xl_d, calc_xr_q, calc_xr_d;
  logic sample_valid_q, sample_valid_d, timeout_q, timeout_d;
  logic signed [17:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic signed [17:0] x_l, x_r;
  logic fold_sign_l, fold_sign_r;

  alu_quadrant_fold u_fold_l (
    .quadrant (phase_l_q[17:16]),
    .theta    (theta_l_q),
    .x        (x_l),
    .sign     (fold_sign_l)
  );

  alu_quadrant_fold u_fold_r (
    .quadrant (phase_r_q[17:16]),
    .theta    (theta_r_q),
    .x        (x_r),
    .sign     (fold_sign_r)
  );

  always_comb begin
    state_d        = state_q;
    phase_l_d      = phase_l_q;
    phase_r_d      = phase_r_q;
    theta_l_d      = theta_l_q;
    theta_r_d      = theta_r_q;
    sign_l_d       = sign_l_q;
    sign_r_d       = sign_r_q;
    calc_start_d   = 1'b0;
    calc_xl_d      = calc_xl_q;
    calc_xr_d      = calc_xr_q;
    sample_valid_d = 1'b0;
    timeout_d      = 1'b0;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    drop_cnt_d     = drop_cnt_q;
    wait_cnt_d     = wait_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (phase_valid) begin
          phase_l_d = phase_l;
          phase_r_d = phase_r;
          state_d   = StScale;
        end
      end
      StScale: begin
        theta_l_d = quarter_angle(phase_l_q[15:0]);
        theta_r_d = quarter_angle(phase_r_q[15:0]);
        sign_l_d  = fold_sign_l;
        sign_r_d  = fold_sign_r;
        state_d   = StIssue;
      end
      StIssue: begin
        calc_xl_d    = x_l;
        calc_xr_d    = x_r;
        calc_start_d = 1'b1;
        wait_cnt_d   = '0;
        state_d      = StWait;
      end
      StWait: begin
        // A result on the expiry edge still wins over the timeout.
        if (calc_done) begin
          sample_l_d     = fix_result(calc_resl, sign_l_q);
          sample_r_d     = fix_result(calc_resr, sign_r_q);
          sample_valid_d = 1'b1;
          state_d        = StIdle;
        end else if (wait_cnt_q == CntLast) begin
          sample_l_d     = '0;
          sample_r_d     = '0;
          sample_valid_d = 1'b1;
          timeout_d      = 1'b1;
          state_d        = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (phase_valid && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      phase_l_q      <= '0;
      phase_r_q      <= '0;
      theta_l_q      <= '0;
      theta_r_q      <= '0;
      sign_l_q       <= 1'b0;
      sign_r_q       <= 1'b0;
      calc_start_q   <= 1'b0;
      calc_xl_q      <= '0;
      calc_xr_q      <= '0;
      sample_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      drop_cnt_q     <= '0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      phase_l_q      <= phase_l_d;
      phase_r_q      <= phase_r_d;
      theta_l_q      <= theta_l_d;
      theta_r_q      <= theta_r_d;
      sign_l_q       <= sign_l_d;
      sign_r_q       <= sign_r_d;
      calc_start_q   <= calc_start_d;
      calc_xl_q      <= calc_xl_d;
      calc_xr_q      <= calc_xr_d;
      sample_valid_q <= sample_valid_d;
      timeout_q      <= timeout_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      drop_cnt_q     <= drop_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign calc_start    = calc_start_q;
  assign calc_func_sel = TAYLOR_FUNC_COS;
  assign calc_xl       = calc_xl_q;
  assign calc_xr       = calc_xr_q;
  assign sample_valid  = sample_valid_q;
  assign sample_l      = sample_l_q;
  assign sample_r      = sample_r_q;
  assign timeout       = timeout_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
